// File: rtl/shift_num_calc.sv
// Block-floating-point shift calculator: ORs per-sample magnitudes over a packet and
// converts the leading-zero count of the result into a left-shift for compress_shift.
module shift_num_calc #(
  parameter int IW        = 40,
  parameter int MAX_SHIFT = 39,
  parameter int LW        = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_sop,
  input  logic          i_eop,
  input  logic          i_vld,
  input  logic [IW-1:0] i_din_re,
  input  logic [IW-1:0] i_din_im,
  output logic [5:0]    o_shift_num,
  output logic          o_shift_vld,
  output logic [LW-1:0] o_pkt_len,
  output logic          o_err
);

  // state | meaning
  // IDLE  | waiting for a valid sop
  // ACC   | inside a packet, OR-accumulating magnitudes and counting samples
  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [5:0]    SH_MAX  = 6'(MAX_SHIFT);
  localparam logic [5:0]    LZ_ZERO = 6'(IW-1);

  state_t        state_q, state_d;
  logic [IW-2:0] acc_q, acc_d;
  logic [LW-1:0] len_q, len_d;
  logic          snap_vld_q, snap_vld_d;
  logic [IW-2:0] snap_q, snap_d;
  logic [LW-1:0] snap_len_q, snap_len_d;
  logic          lz_vld_q, lz_vld_d;
  logic [5:0]    lz_q, lz_d;
  logic [LW-1:0] lz_len_q, lz_len_d;
  logic [5:0]    shift_num_q, shift_num_d;
  logic          shift_vld_q, shift_vld_d;
  logic [LW-1:0] pkt_len_q, pkt_len_d;
  logic          err_q, err_d;

  logic [IW-2:0] m_or;
  logic [LW-1:0] len_inc;

  // The sign bit of x ^ {IW{sign}} is always zero, so only the lower IW-1 bits are kept.
  assign m_or    = (i_din_re[IW-2:0] ^ {(IW-1){i_din_re[IW-1]}})
                 | (i_din_im[IW-2:0] ^ {(IW-1){i_din_im[IW-1]}});
  assign len_inc = (len_q == '1) ? len_q : len_q + LEN_ONE;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    len_d      = len_q;
    snap_vld_d = 1'b0;
    snap_d     = snap_q;
    snap_len_d = snap_len_q;
    err_d      = 1'b0;
    if (i_vld) begin
      unique case (state_q)
        IDLE: begin
          if (i_sop && i_eop) begin
            snap_vld_d = 1'b1;
            snap_d     = m_or;
            snap_len_d = LEN_ONE;
          end else if (i_sop) begin
            acc_d   = m_or;
            len_d   = LEN_ONE;
            state_d = ACC;
          end else if (i_eop) begin
            err_d = 1'b1;
          end
        end
        ACC: begin
          if (i_sop && i_eop) begin
            snap_vld_d = 1'b1;
            snap_d     = m_or;
            snap_len_d = LEN_ONE;
            state_d    = IDLE;
          end else if (i_sop) begin
            err_d = 1'b1;
            acc_d = m_or;
            len_d = LEN_ONE;
          end else if (i_eop) begin
            snap_vld_d = 1'b1;
            snap_d     = acc_q | m_or;
            snap_len_d = len_inc;
            state_d    = IDLE;
          end else begin
            acc_d = acc_q | m_or;
            len_d = len_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Scanning upward lets the highest set bit overwrite any lower one.
  always_comb begin
    lz_vld_d = snap_vld_q;
    lz_len_d = snap_len_q;
    lz_d     = LZ_ZERO;
    for (int i = 0; i < IW-1; i++) begin
      if (snap_q[i]) lz_d = 6'(IW-2-i);
    end
  end

  always_comb begin
    shift_vld_d = lz_vld_q;
    shift_num_d = shift_num_q;
    pkt_len_d   = pkt_len_q;
    if (lz_vld_q) begin
      shift_num_d = (lz_q > SH_MAX) ? SH_MAX : lz_q;
      pkt_len_d   = lz_len_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      len_q       <= '0;
      snap_vld_q  <= 1'b0;
      snap_q      <= '0;
      snap_len_q  <= '0;
      lz_vld_q    <= 1'b0;
      lz_q        <= '0;
      lz_len_q    <= '0;
      shift_num_q <= '0;
      shift_vld_q <= 1'b0;
      pkt_len_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      snap_vld_q  <= snap_vld_d;
      snap_q      <= snap_d;
      snap_len_q  <= snap_len_d;
      lz_vld_q    <= lz_vld_d;
      lz_q        <= lz_d;
      lz_len_q    <= lz_len_d;
      shift_num_q <= shift_num_d;
      shift_vld_q <= shift_vld_d;
      pkt_len_q   <= pkt_len_d;
      err_q       <= err_d;
    end
  end

  assign o_shift_num = shift_num_q;
  assign o_shift_vld = shift_vld_q;
  assign o_pkt_len   = pkt_len_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_shift_num_calc.sv
// Scoreboard bench for shift_num_calc: directed packets push expected results,
// a negedge monitor pops and compares on every o_shift_vld / o_err pulse.
module tb_shift_num_calc;
  localparam int IW = 40;
  localparam int LW = 12;
  localparam logic [IW-1:0] BIG = 40'h7F_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_sop = 1'b0, i_eop = 1'b0, i_vld = 1'b0;
  logic [IW-1:0] i_din_re = '0, i_din_im = '0;
  logic [5:0]    sh0, sh1;
  logic          vld0, vld1, err0, err1;
  logic [LW-1:0] len0, len1;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {int sh; int len; int cyc;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   eq[$];

  shift_num_calc #(.IW(IW), .MAX_SHIFT(39), .LW(LW)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
    .i_din_re(i_din_re), .i_din_im(i_din_im),
    .o_shift_num(sh0), .o_shift_vld(vld0), .o_pkt_len(len0), .o_err(err0));

  shift_num_calc #(.IW(IW), .MAX_SHIFT(20), .LW(LW)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
    .i_din_re(i_din_re), .i_din_im(i_din_im),
    .o_shift_num(sh1), .o_shift_vld(vld1), .o_pkt_len(len1), .o_err(err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic beat(input logic v, input logic s, input logic e,
                      input logic [IW-1:0] re, input logic [IW-1:0] im);
    @(posedge clk);
    #1;
    i_vld = v; i_sop = s; i_eop = e; i_din_re = re; i_din_im = im;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Call right after the eop beat is driven; lz is the hand-computed leading-zero count.
  task automatic expect_pkt(input int lz, input int len);
    exp_t e;
    e.len = len;
    e.cyc = cyc + 3;
    e.sh  = (lz > 39) ? 39 : lz;
    q0.push_back(e);
    e.sh  = (lz > 20) ? 20 : lz;
    q1.push_back(e);
  endtask

  task automatic expect_err();
    eq.push_back(cyc + 1);
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0; i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    #1;
    check("rst_async_shift", 64'(sh0), 0);
    check("rst_async_vld", 64'(vld0), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (vld0) begin
      if (q0.size() == 0) check("spurious_vld0", 64'(vld0), 0);
      else begin
        e = q0.pop_front();
        check("shift0", 64'(sh0), 64'(e.sh));
        check("len0", 64'(len0), 64'(e.len));
        check("latency0", 64'(cyc), 64'(e.cyc));
      end
    end
    if (vld1) begin
      if (q1.size() == 0) check("spurious_vld1", 64'(vld1), 0);
      else begin
        e = q1.pop_front();
        check("shift1_clip20", 64'(sh1), 64'(e.sh));
        check("len1", 64'(len1), 64'(e.len));
      end
    end
    if (err0) begin
      if (eq.size() == 0) check("spurious_err", 64'(err0), 0);
      else check("err_cycle", 64'(cyc), 64'(eq.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_shift", 64'(sh0), 0);
    check("reset_len", 64'(len0), 0);
    check("reset_vld", 64'(vld0), 0);
    check("reset_err", 64'(err0), 0);
    rst_n = 1'b1;
    idle(2);

    // 4-sample packet, max re = 0x1234 -> bit 12 -> 26
    beat(1, 1, 0, '0, '0);
    beat(1, 0, 0, 40'h1234, '0);
    beat(1, 0, 0, '0, '0);
    beat(1, 0, 1, '0, '0); expect_pkt(26, 4);
    idle(1);

    // consecutive single-sample packets
    beat(1, 1, 1, 40'h80_0000_0000, '0); expect_pkt(0, 1);
    beat(1, 1, 1, '1, '1);               expect_pkt(39, 1);
    beat(1, 1, 1, 40'h12, 40'hFF_FFFF_F000); expect_pkt(27, 1);

    // maximum carried by the imaginary part
    beat(1, 1, 0, '0, 40'hFF_FFFF_F000);
    beat(1, 0, 1, 40'h3, '0); expect_pkt(27, 2);
    idle(1);

    // vld without sop in IDLE and sop/eop with vld=0 are ignored
    beat(1, 0, 0, BIG, '0);
    beat(0, 1, 1, BIG, BIG);
    beat(1, 1, 0, 40'h100, '0);
    beat(0, 1, 1, BIG, BIG);
    beat(1, 0, 1, '0, '0); expect_pkt(30, 2);
    idle(2);

    // sop inside a packet: error, restart; 6 samples counted from the second sop
    beat(1, 1, 0, BIG, '0);
    for (int k = 0; k < 4; k++) beat(1, 0, 0, BIG, '0);
    beat(1, 1, 0, 40'h1000, '0); expect_err();
    for (int k = 0; k < 4; k++) beat(1, 0, 0, '0, '0);
    beat(1, 0, 1, '0, '0); expect_pkt(26, 6);
    idle(2);

    // eop in IDLE: error only
    beat(1, 0, 1, 40'h5, '0); expect_err();
    idle(1);

    // back-to-back packets, then sop&eop while in ACC
    beat(1, 1, 0, '0, '0);
    beat(1, 0, 0, 40'h1, '0);
    beat(1, 0, 1, '0, '0); expect_pkt(38, 3);
    beat(1, 1, 0, BIG, '0);
    beat(1, 0, 1, '0, '0); expect_pkt(0, 2);
    beat(1, 1, 0, BIG, '0);
    beat(1, 1, 1, 40'h400, '0); expect_pkt(28, 1);
    idle(2);

    // all-zero 1584-sample packet with gaps carrying junk
    for (int k = 0; k < 1584; k++) begin
      beat(1, k == 0, k == 1583, '0, '0);
      if (k == 1583) expect_pkt(39, 1584);
      else if (k % 3 == 1) beat(0, 1, 1, BIG, BIG);
    end
    idle(5);

    // reset mid-packet; a stray eop afterwards must be an IDLE framing error
    beat(1, 1, 0, BIG, '0);
    beat(1, 0, 0, '0, '0);
    rst_pulse();
    beat(1, 0, 1, '0, '0); expect_err();
    beat(1, 1, 0, 40'h2, '0);
    beat(1, 0, 1, '0, '0); expect_pkt(37, 2);
    idle(5);

    // reset while a result is in the calc pipeline
    beat(1, 1, 1, BIG, '0);
    rst_pulse();
    idle(5);
    beat(1, 1, 1, 40'h8, '0); expect_pkt(35, 1);
    idle(6);

    check("q0_drained", 64'(q0.size()), 0);
    check("q1_drained", 64'(q1.size()), 0);
    check("err_drained", 64'(eq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
